// File: rtl/uart_rx_pkg.sv
// Shared serial-link definitions: receiver state encodings and the default
// 250 kbaud bit period used by both the transmitter and the receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

  // 12 MHz board clock / 250 kbaud
  localparam int CLKS_PER_BIT_250K = 48;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so idle-high and idle-low lines can both use it.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk12MHz,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronised rx line, mid-bit sampling, holding register
// with valid/ack handshake, framing-error and overrun pulses.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | line idle, waiting for rxS low
//   START     | timing half a bit to re-check the start bit
//   DATA      | sampling the 8 data bits, LSB first, once per bit period
//   STOP      | waiting for the stop-bit sample, then deliver/overrun/error
//   WAIT_IDLE | after a framing error, waiting for the line to return high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_250K
) (
  input  logic       clk12MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] recvData,
  output logic       recvValid,
  input  logic       recvAck,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  logic rxS;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .d        (rx),
    .q        (rxS)
  );

  uart_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tick;
  logic          load, ovr, ferr;

  // Bit timer counts down to zero; zero marks a sample point.
  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    load      = 1'b0;
    ovr       = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = HALF_LOAD;
        idx_nxt = 3'd0;
        if (!rxS) state_nxt = START;
      end
      START: begin
        if (tick) begin
          cnt_nxt   = BIT_LOAD;
          state_nxt = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_nxt   = BIT_LOAD;
          shift_nxt = {rxS, shift[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_nxt = HALF_LOAD;
          if (rxS) begin
            // An ack in the same cycle frees the holding register in time.
            if (!recvValid || recvAck) load = 1'b1;
            else                       ovr  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = HALF_LOAD;
        if (rxS) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = HALF_LOAD;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= HALF_LOAD;
      idx        <= 3'd0;
      shift      <= 8'h00;
      recvData   <= 8'h00;
      recvValid  <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      frameError <= ferr;
      overrun    <= ovr;
      if (load) begin
        recvData  <= shift;
        recvValid <= 1'b1;
      end else if (recvAck) begin
        recvValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitch, break, overrun, ack timing and mid-frame reset.
module tb_uart_rx;

  localparam int CPB     = 48;
  localparam int HALF    = CPB / 2;
  localparam int LAT     = 459;   // rx pin edge to recvValid rise

  logic       clk12MHz = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] recvData;
  logic       recvValid;
  logic       recvAck;
  logic       frameError;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk12MHz   (clk12MHz),
    .reset      (reset),
    .rx         (rx),
    .recvData   (recvData),
    .recvValid  (recvValid),
    .recvAck    (recvAck),
    .frameError (frameError),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #41 clk12MHz = ~clk12MHz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int rise_cnt, rise_cyc, fe_cnt, ov_cnt, ov_cyc, both_cnt, busy_run, busy_max;
  logic prev_valid = 1'b0;

  always @(posedge clk12MHz) cyc++;

  always @(negedge clk12MHz) begin
    if (recvValid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = recvValid;
    if (frameError) fe_cnt++;
    if (overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (frameError && overrun) both_cnt++;
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    rise_cnt = 0; fe_cnt = 0; ov_cnt = 0; both_cnt = 0;
    busy_max = 0; busy_run = 0; rise_cyc = 0; ov_cyc = 0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk12MHz);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the line high again.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int extra_low);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stopb);
    if (!stopb) begin
      repeat (extra_low) @(posedge clk12MHz);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk12MHz);
    #1;
  endtask

  task automatic ack_pulse(input string name);
    recvAck = 1'b1;
    @(posedge clk12MHz);
    #1;
    recvAck = 1'b0;
    @(negedge clk12MHz);
    check({name, "_ack_clear"}, recvValid, 1'b0);
    idle(1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] got_b[2];

  initial begin
    vecs[0] = '{8'hA1, 1'b1, 8'hA1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[3] = '{8'h5A, 1'b0, 8'hFF, 1'b0, 1};
    vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b1, 0};

    reset = 1'b1; rx = 1'b1; recvAck = 1'b0;
    clear_counts();
    idle(4);
    reset = 1'b0;
    @(negedge clk12MHz);
    check("rst_data",  recvData,   8'h00);
    check("rst_valid", recvValid,  1'b0);
    check("rst_fe",    frameError, 1'b0);
    check("rst_ov",    overrun,    1'b0);
    check("rst_busy",  busy,       1'b0);
    idle(3);

    for (int v = 0; v < 6; v++) begin
      clear_counts();
      send_frame(vecs[v].data, vecs[v].stopb, 0);
      idle(10);
      @(negedge clk12MHz);
      check($sformatf("vec%0d_valid", v), recvValid, vecs[v].exp_valid);
      check($sformatf("vec%0d_data", v),  recvData,  vecs[v].exp_data);
      check($sformatf("vec%0d_fe", v),    fe_cnt,    vecs[v].exp_fe);
      check($sformatf("vec%0d_ov", v),    ov_cnt,    0);
      check($sformatf("vec%0d_busy", v),  busy,      1'b0);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_latency", v), rise_cyc - start_cyc, LAT);
        idle(1);
        ack_pulse($sformatf("vec%0d", v));
      end else begin
        idle(1);
      end
    end

    // Short glitch on the line: rejected at the start-bit sample
    clear_counts();
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(60);
    @(negedge clk12MHz);
    check("glitch_valid", rise_cnt, 0);
    check("glitch_fe",    fe_cnt,   0);
    check("glitch_busy_max", busy_max, HALF);
    check("glitch_busy_end", busy,  1'b0);
    idle(1);

    // Break: stop bit low and line held low, then a good frame
    clear_counts();
    send_frame(8'h55, 1'b0, 200);
    idle(20);
    @(negedge clk12MHz);
    check("break_fe",    fe_cnt,    1);
    check("break_valid", recvValid, 1'b0);
    check("break_both",  both_cnt,  0);
    idle(1);
    send_frame(8'h3C, 1'b1, 0);
    idle(5);
    @(negedge clk12MHz);
    check("after_break_valid", recvValid, 1'b1);
    check("after_break_data",  recvData,  8'h3C);
    check("after_break_fe",    fe_cnt,    1);
    idle(1);
    ack_pulse("after_break");

    // Back-to-back without ack: second frame overruns
    clear_counts();
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    idle(10);
    @(negedge clk12MHz);
    check("ovr_data",  recvData,  8'h12);
    check("ovr_valid", recvValid, 1'b1);
    check("ovr_count", ov_cnt,    1);
    check("ovr_time",  ov_cyc - start_cyc, LAT);
    check("ovr_fe",    fe_cnt,    0);
    check("ovr_rises", rise_cnt,  1);
    idle(1);
    ack_pulse("ovr");

    // Back-to-back with ack 100 cycles after each valid
    clear_counts();
    fork
      begin
        send_frame(8'h12, 1'b1, 0);
        send_frame(8'h34, 1'b1, 0);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int w;
          w = 0;
          @(negedge clk12MHz);
          while (!recvValid && w < 2000) begin
            @(negedge clk12MHz);
            w++;
          end
          check($sformatf("ackseq_wait%0d", k), (w < 2000), 1'b1);
          repeat (100) @(posedge clk12MHz);
          #1;
          got_b[k] = recvData;
          check($sformatf("ackseq_held%0d", k), recvValid, 1'b1);
          recvAck = 1'b1;
          @(posedge clk12MHz);
          #1;
          recvAck = 1'b0;
          @(negedge clk12MHz);
          check($sformatf("ackseq_clear%0d", k), recvValid, 1'b0);
        end
      end
    join
    check("ackseq_byte0", got_b[0], 8'h12);
    check("ackseq_byte1", got_b[1], 8'h34);
    check("ackseq_ov",    ov_cnt,   0);
    idle(5);

    // Pending byte, then ack in the exact cycle of the next stop sample
    clear_counts();
    send_frame(8'hC3, 1'b1, 0);
    idle(5);
    fork
      send_frame(8'h96, 1'b1, 0);
      begin
        repeat (LAT - 1) @(posedge clk12MHz);
        #1;
        recvAck = 1'b1;
        @(posedge clk12MHz);
        #1;
        recvAck = 1'b0;
      end
    join
    idle(5);
    @(negedge clk12MHz);
    check("sameack_valid", recvValid, 1'b1);
    check("sameack_data",  recvData,  8'h96);
    check("sameack_ov",    ov_cnt,    0);
    idle(1);

    // Reset in the middle of the data bits of 0xFF, byte 0x96 still pending
    clear_counts();
    start_cyc = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    idle(10);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rx = 1'b1;
    @(negedge clk12MHz);
    check("midrst_data",  recvData,   8'h00);
    check("midrst_valid", recvValid,  1'b0);
    check("midrst_busy",  busy,       1'b0);
    check("midrst_fe",    frameError, 1'b0);
    check("midrst_ov",    overrun,    1'b0);
    idle(500);
    check("midrst_quiet", fe_cnt + ov_cnt + rise_cnt, 0);
    send_frame(8'h81, 1'b1, 0);
    idle(5);
    @(negedge clk12MHz);
    check("midrst_next_valid", recvValid, 1'b1);
    check("midrst_next_data",  recvData,  8'h81);
    check("midrst_next_lat",   rise_cyc - start_cyc, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
